// File: rtl/dds_serial_loader.sv
// Serial programmer for AD985x-class DDS parts: drives reset, w_clk, fq_ud and data,
// with a serial-mode init sequence, busy/done handshake and a one-deep load queue.
module dds_serial_loader #(
    parameter int WORD_W    = 40,
    parameter int DIV       = 4,
    parameter int RST_CYC   = 8,
    parameter int FQ_CYC    = 4,
    parameter bit LSB_FIRST = 1'b1,
    parameter bit AUTO_INIT = 1'b1
) (
    input  logic              clk_sys,
    input  logic              rst,
    input  logic              init,
    input  logic              load,
    input  logic [WORD_W-1:0] word,
    output logic              busy,
    output logic              done,
    output logic              pending,
    output logic              dds_reset,
    output logic              w_clk,
    output logic              fq_ud,
    output logic              data
);

    localparam int MAX_LEN = (DIV > RST_CYC) ? ((DIV > FQ_CYC) ? DIV : FQ_CYC)
                                             : ((RST_CYC > FQ_CYC) ? RST_CYC : FQ_CYC);
    localparam int CNT_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int BIT_W = $clog2(WORD_W);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] FQ_LAST  = CNT_W'(FQ_CYC - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RST   = 3'd1;
    localparam logic [2:0] S_EN_LO = 3'd2;
    localparam logic [2:0] S_EN_HI = 3'd3;
    localparam logic [2:0] S_SH_LO = 3'd4;
    localparam logic [2:0] S_SH_HI = 3'd5;
    localparam logic [2:0] S_FQ    = 3'd6;

    logic [2:0]        state, state_nx;
    logic [CNT_W-1:0]  cnt, state_last;
    logic [BIT_W-1:0]  bit_cnt;
    logic [WORD_W-1:0] shreg, shreg_sh, pend_word;
    logic              init_pend;
    logic              last, init_req, start_init, start_pend, start_load;
    logic              queue_load, shift_next, data_nx;

    function automatic logic first_bit(input logic [WORD_W-1:0] v);
        return LSB_FIRST ? v[0] : v[WORD_W-1];
    endfunction

    // NOTE: every signal gets a default at the top of the block so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_last = DIV_LAST;
        state_nx   = state;
        data_nx    = 1'b0;
        case (state)
            S_RST:   state_last = RST_LAST;
            S_FQ:    state_last = FQ_LAST;
            default: state_last = DIV_LAST;
        endcase
        last       = (cnt == state_last);
        init_req   = init | init_pend;
        start_init = (state == S_IDLE) && init_req;
        start_pend = (state == S_IDLE) && !init_req && pending;
        start_load = (state == S_IDLE) && !init_req && !pending && load;
        queue_load = load && !start_load;
        shift_next = (state == S_SH_HI) && last && (bit_cnt != BIT_LAST);
        shreg_sh   = LSB_FIRST ? (shreg >> 1) : (shreg << 1);

        case (state)
            S_IDLE:  if (start_init) state_nx = S_RST;
                     else if (start_pend || start_load) state_nx = S_SH_LO;
            S_RST:   if (last) state_nx = S_EN_LO;
            S_EN_LO: if (last) state_nx = S_EN_HI;
            S_EN_HI: if (last) state_nx = S_FQ;
            S_SH_LO: if (last) state_nx = S_SH_HI;
            S_SH_HI: if (last) state_nx = (bit_cnt == BIT_LAST) ? S_FQ : S_SH_LO;
            S_FQ:    if (last) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase

        // Data only changes when a bit slot opens, so it is stable across the whole w_clk pulse.
        if (start_pend)
            data_nx = first_bit(pend_word);
        else if (start_load)
            data_nx = first_bit(word);
        else if (shift_next)
            data_nx = first_bit(shreg_sh);
        else if (state_nx == S_SH_LO || state_nx == S_SH_HI)
            data_nx = data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            pend_word <= '0;
            pending   <= 1'b0;
            init_pend <= AUTO_INIT;
            busy      <= 1'b0;
            done      <= 1'b0;
            dds_reset <= 1'b0;
            w_clk     <= 1'b0;
            fq_ud     <= 1'b0;
            data      <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= (state_nx != state || state == S_IDLE) ? '0 : cnt + 1'b1;

            if (start_pend || start_load)
                bit_cnt <= '0;
            else if (shift_next)
                bit_cnt <= bit_cnt + 1'b1;

            if (start_pend)
                shreg <= pend_word;
            else if (start_load)
                shreg <= word;
            else if (shift_next)
                shreg <= shreg_sh;

            // A load that cannot start right now lands in the slot; the newest word wins.
            if (queue_load) begin
                pending   <= 1'b1;
                pend_word <= word;
            end else if (start_pend) begin
                pending <= 1'b0;
            end

            if (state == S_IDLE)
                init_pend <= 1'b0;
            else if (init)
                init_pend <= 1'b1;

            busy      <= (state_nx != S_IDLE);
            done      <= (state == S_FQ) && last;
            dds_reset <= (state_nx == S_RST);
            w_clk     <= (state_nx == S_EN_HI) || (state_nx == S_SH_HI);
            fq_ud     <= (state_nx == S_FQ);
            data      <= data_nx;
        end
    end

endmodule

// File: tb/tb_dds_serial_loader.sv
// Bench for dds_serial_loader: three parameterisations run side by side against a
// waveform-level reference model of the init/load sequences and the request queue.
module tb_dds_serial_loader;

    localparam int ND     = 3;
    localparam int K_NONE = 0;
    localparam int K_INIT = 1;
    localparam int K_LOAD = 2;

    int p_w    [ND] = '{40, 16, 40};
    int p_div  [ND] = '{4, 1, 4};
    int p_rc   [ND] = '{8, 3, 8};
    int p_fq   [ND] = '{4, 1, 4};
    bit p_lsb  [ND] = '{1'b1, 1'b0, 1'b0};
    bit p_auto [ND] = '{1'b1, 1'b0, 1'b1};

    logic        clk_sys = 1'b0;
    logic        rst = 1'b1;
    logic        init_i [ND];
    logic        load_i [ND];
    logic [39:0] word_i [ND];
    wire  [6:0]  pins   [ND];   // {busy, done, pending, dds_reset, w_clk, fq_ud, data}
    logic [6:0]  act_v  [ND];
    logic [6:0]  exp_v  [ND];

    int          m_kind  [ND];
    int          m_start [ND];
    logic [39:0] m_word  [ND];
    bit          m_pend  [ND];
    logic [39:0] m_pword [ND];
    bit          m_ipend [ND];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk_sys = ~clk_sys;

    dds_serial_loader #(.WORD_W(40), .DIV(4), .RST_CYC(8), .FQ_CYC(4),
                        .LSB_FIRST(1'b1), .AUTO_INIT(1'b1)) dut0 (
        .clk_sys(clk_sys), .rst(rst), .init(init_i[0]), .load(load_i[0]), .word(word_i[0]),
        .busy(pins[0][6]), .done(pins[0][5]), .pending(pins[0][4]), .dds_reset(pins[0][3]),
        .w_clk(pins[0][2]), .fq_ud(pins[0][1]), .data(pins[0][0]));

    dds_serial_loader #(.WORD_W(16), .DIV(1), .RST_CYC(3), .FQ_CYC(1),
                        .LSB_FIRST(1'b0), .AUTO_INIT(1'b0)) dut1 (
        .clk_sys(clk_sys), .rst(rst), .init(init_i[1]), .load(load_i[1]), .word(word_i[1][15:0]),
        .busy(pins[1][6]), .done(pins[1][5]), .pending(pins[1][4]), .dds_reset(pins[1][3]),
        .w_clk(pins[1][2]), .fq_ud(pins[1][1]), .data(pins[1][0]));

    dds_serial_loader #(.WORD_W(40), .DIV(4), .RST_CYC(8), .FQ_CYC(4),
                        .LSB_FIRST(1'b0), .AUTO_INIT(1'b1)) dut2 (
        .clk_sys(clk_sys), .rst(rst), .init(init_i[2]), .load(load_i[2]), .word(word_i[2]),
        .busy(pins[2][6]), .done(pins[2][5]), .pending(pins[2][4]), .dds_reset(pins[2][3]),
        .w_clk(pins[2][2]), .fq_ud(pins[2][1]), .data(pins[2][0]));

    // Total cycles of a sequence, counting its trailing done cycle.
    function automatic int seq_len(input int d, input int kind);
        if (kind == K_LOAD) return 2 * p_div[d] * p_w[d] + p_fq[d] + 1;
        return p_rc[d] + 2 * p_div[d] + p_fq[d] + 1;
    endfunction

    // Pins {busy, done, dds_reset, w_clk, fq_ud, data} at cycle 'off' of a sequence.
    function automatic logic [5:0] seq_pins(input int d, input int kind, input int off,
                                            input logic [39:0] w);
        int   half, body, n;
        logic hi, b;
        half = p_div[d];
        if (kind == K_LOAD) begin
            body = 2 * half * p_w[d];
            if (off < body) begin
                n  = off / (2 * half);
                hi = ((off % (2 * half)) >= half);
                b  = p_lsb[d] ? w[n] : w[p_w[d] - 1 - n];
                return {1'b1, 1'b0, 1'b0, hi, 1'b0, b};
            end
            if (off < body + p_fq[d]) return 6'b100010;
            return 6'b010000;
        end
        if (off < p_rc[d])                    return 6'b101000;
        if (off < p_rc[d] + half)             return 6'b100000;
        if (off < p_rc[d] + 2 * half)         return 6'b100100;
        if (off < p_rc[d] + 2 * half + p_fq[d]) return 6'b100010;
        return 6'b010000;
    endfunction

    task automatic model_edge();
        logic [5:0] p;
        for (int d = 0; d < ND; d++) begin
            if (rst) begin
                m_kind[d]  = K_NONE;
                m_pend[d]  = 1'b0;
                m_pword[d] = '0;
                m_ipend[d] = p_auto[d];
                exp_v[d]   = '0;
            end else begin
                if (m_kind[d] != K_NONE && cyc - m_start[d] >= seq_len(d, m_kind[d]))
                    m_kind[d] = K_NONE;
                if (m_kind[d] == K_NONE) begin
                    if (init_i[d] || m_ipend[d]) begin
                        m_kind[d] = K_INIT; m_start[d] = cyc; m_ipend[d] = 1'b0;
                        if (load_i[d]) begin m_pend[d] = 1'b1; m_pword[d] = word_i[d]; end
                    end else if (m_pend[d]) begin
                        m_kind[d] = K_LOAD; m_start[d] = cyc; m_word[d] = m_pword[d];
                        m_pend[d] = 1'b0;
                        if (load_i[d]) begin m_pend[d] = 1'b1; m_pword[d] = word_i[d]; end
                    end else if (load_i[d]) begin
                        m_kind[d] = K_LOAD; m_start[d] = cyc; m_word[d] = word_i[d];
                    end
                end else begin
                    if (init_i[d]) m_ipend[d] = 1'b1;
                    if (load_i[d]) begin m_pend[d] = 1'b1; m_pword[d] = word_i[d]; end
                end
                p = (m_kind[d] == K_NONE) ? 6'b0
                                          : seq_pins(d, m_kind[d], cyc - m_start[d], m_word[d]);
                exp_v[d] = {p[5], p[4], m_pend[d], p[3:0]};
            end
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        model_edge();
        cyc++;
        #1;
        for (int d = 0; d < ND; d++) begin
            act_v[d]  = pins[d];
            init_i[d] = 1'b0;
            load_i[d] = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (3) begin
            step();
            for (int d = 0; d < ND; d++) begin
                n_vec++;
                if (act_v[d] !== exp_v[d]) begin
                    n_err++;
                    $display("FAIL reset dut%0d cyc %0d: got %b want %b", d, cyc, act_v[d], exp_v[d]);
                end
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_auto_init();
        int done_at = -1, rst_hi = 0, wclk_hi = 0, fq_hi = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            for (int d = 0; d < ND; d++) begin
                n_vec++;
                if (act_v[d] !== exp_v[d]) begin
                    n_err++;
                    $display("FAIL auto_init dut%0d cyc %0d: got %b want %b", d, cyc, act_v[d], exp_v[d]);
                end
            end
            rst_hi  += int'(act_v[0][3]);
            wclk_hi += int'(act_v[0][2]);
            fq_hi   += int'(act_v[0][1]);
            if (act_v[0][5] && done_at < 0) done_at = i;
        end
        n_vec++;
        if (done_at !== 20) begin
            n_err++; $display("FAIL auto_init_done_cycle: got %0d want 20", done_at);
        end
        n_vec++;
        if (rst_hi !== 8 || wclk_hi !== 4 || fq_hi !== 4) begin
            n_err++;
            $display("FAIL auto_init_widths: got rst=%0d wclk=%0d fq=%0d want 8/4/4", rst_hi, wclk_hi, fq_hi);
        end
    endtask

    task automatic test_single_load();
        int done0 = -1, done1 = -1, rises = 0, d0_hi = 0, d2_hi = 0;
        logic prev_w = 1'b0;
        word_i[0] = 40'h00_0000_0001;
        word_i[1] = 40'h00_0000_8000;
        word_i[2] = 40'h80_0000_0000;
        for (int d = 0; d < ND; d++) load_i[d] = 1'b1;
        for (int i = 0; i < 330; i++) begin
            step();
            for (int d = 0; d < ND; d++) begin
                n_vec++;
                if (act_v[d] !== exp_v[d]) begin
                    n_err++;
                    $display("FAIL single_load dut%0d cyc %0d: got %b want %b", d, cyc, act_v[d], exp_v[d]);
                end
            end
            if (act_v[0][2] && !prev_w) rises++;
            prev_w = act_v[0][2];
            d0_hi += int'(act_v[0][0]);
            d2_hi += int'(act_v[2][0]);
            if (act_v[0][5] && done0 < 0) done0 = i;
            if (act_v[1][5] && done1 < 0) done1 = i;
        end
        n_vec++;
        if (done0 !== 324 || done1 !== 33) begin
            n_err++; $display("FAIL load_done_cycle: got %0d/%0d want 324/33", done0, done1);
        end
        n_vec++;
        if (rises !== 40) begin
            n_err++; $display("FAIL load_wclk_rises: got %0d want 40", rises);
        end
        n_vec++;
        if (d0_hi !== 8 || d2_hi !== 8) begin
            n_err++; $display("FAIL load_data_bit0_only: got %0d/%0d want 8/8", d0_hi, d2_hi);
        end
    endtask

    task automatic test_queued_load();
        logic p49 = 1'b0, p50 = 1'b0, p325 = 1'b1;
        for (int i = 0; i < 660; i++) begin
            for (int d = 0; d < ND; d++) begin
                if (i == 0)  begin load_i[d] = 1'b1; word_i[d] = 40'h12_3456_789A; end
                if (i == 50) begin load_i[d] = 1'b1; word_i[d] = 40'hB0_B0B0_B0B0; end
                if (i == 60) begin load_i[d] = 1'b1; word_i[d] = 40'h3C_C3C3_5AA5; end
            end
            step();
            for (int d = 0; d < ND; d++) begin
                n_vec++;
                if (act_v[d] !== exp_v[d]) begin
                    n_err++;
                    $display("FAIL queued_load dut%0d cyc %0d: got %b want %b", d, cyc, act_v[d], exp_v[d]);
                end
            end
            if (i == 49)  p49  = act_v[0][4];
            if (i == 50)  p50  = act_v[0][4];
            if (i == 325) p325 = act_v[0][4];
        end
        n_vec++;
        if (p49 !== 1'b0 || p50 !== 1'b1 || p325 !== 1'b0) begin
            n_err++; $display("FAIL queued_pending_flag: got %b%b%b want 010", p49, p50, p325);
        end
    endtask

    task automatic test_init_during_load();
        logic r325 = 1'b0, b346 = 1'b0;
        for (int i = 0; i < 680; i++) begin
            for (int d = 0; d < ND; d++) begin
                if (i == 0)   begin load_i[d] = 1'b1; word_i[d] = 40'hDE_ADBE_EF01; end
                if (i == 100) init_i[d] = 1'b1;
                if (i == 150) begin load_i[d] = 1'b1; word_i[d] = 40'h0F_1E2D_3C4B; end
            end
            step();
            for (int d = 0; d < ND; d++) begin
                n_vec++;
                if (act_v[d] !== exp_v[d]) begin
                    n_err++;
                    $display("FAIL init_during_load dut%0d cyc %0d: got %b want %b", d, cyc, act_v[d], exp_v[d]);
                end
            end
            if (i == 325) r325 = act_v[0][3];
            if (i == 346) b346 = act_v[0][6];
        end
        n_vec++;
        if (r325 !== 1'b1 || b346 !== 1'b1) begin
            n_err++; $display("FAIL init_after_load_order: got reset=%b busy=%b want 1/1", r325, b346);
        end
    endtask

    task automatic test_back_to_back();
        int  waited = 0;
        bit  seen = 1'b0;
        for (int d = 0; d < ND; d++) begin load_i[d] = 1'b1; word_i[d] = 40'h5A_A55A_A55A; end
        while (!seen && waited < 400) begin
            step();
            for (int d = 0; d < ND; d++) begin
                n_vec++;
                if (act_v[d] !== exp_v[d]) begin
                    n_err++;
                    $display("FAIL back_to_back dut%0d cyc %0d: got %b want %b", d, cyc, act_v[d], exp_v[d]);
                end
            end
            waited++;
            if (act_v[0][5]) seen = 1'b1;
        end
        n_vec++;
        if (!seen) begin
            n_err++; $display("FAIL back_to_back_done_timeout: got no done want done within 400");
        end
        for (int d = 0; d < ND; d++) begin load_i[d] = 1'b1; word_i[d] = 40'hC3_0F0F_F0F0; end
        for (int i = 0; i < 340; i++) begin
            step();
            for (int d = 0; d < ND; d++) begin
                n_vec++;
                if (act_v[d] !== exp_v[d]) begin
                    n_err++;
                    $display("FAIL back_to_back dut%0d cyc %0d: got %b want %b", d, cyc, act_v[d], exp_v[d]);
                end
            end
            if (i == 0) begin
                n_vec++;
                if (act_v[0][6] !== 1'b1) begin
                    n_err++; $display("FAIL back_to_back_immediate_start: got busy=%b want 1", act_v[0][6]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_shift();
        int data_after = 0;
        for (int d = 0; d < ND; d++) begin load_i[d] = 1'b1; word_i[d] = 40'hFF_FFFF_FFFF; end
        for (int i = 0; i < 100; i++) begin
            step();
            for (int d = 0; d < ND; d++) begin
                n_vec++;
                if (act_v[d] !== exp_v[d]) begin
                    n_err++;
                    $display("FAIL reset_mid_shift dut%0d cyc %0d: got %b want %b", d, cyc, act_v[d], exp_v[d]);
                end
            end
        end
        #3 rst = 1'b1;
        #1;
        for (int d = 0; d < ND; d++) begin
            n_vec++;
            if (pins[d] !== 7'b0) begin
                n_err++; $display("FAIL async_reset dut%0d: got %b want 0000000", d, pins[d]);
            end
        end
        for (int i = 0; i < 42; i++) begin
            step();
            if (i == 1) rst = 1'b0;
            for (int d = 0; d < ND; d++) begin
                n_vec++;
                if (act_v[d] !== exp_v[d]) begin
                    n_err++;
                    $display("FAIL reset_release dut%0d cyc %0d: got %b want %b", d, cyc, act_v[d], exp_v[d]);
                end
            end
            if (i >= 2) data_after += int'(act_v[0][0]);
        end
        n_vec++;
        if (data_after !== 0) begin
            n_err++; $display("FAIL no_resumed_shift: got %0d data-high cycles want 0", data_after);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            for (int d = 0; d < ND; d++) begin
                init_i[d] = ($urandom_range(0, 199) == 0);
                load_i[d] = ($urandom_range(0, 29) == 0);
                word_i[d] = {8'($urandom()), $urandom()};
            end
            if ($urandom_range(0, 999) == 0) rst = 1'b1;
            step();
            rst = 1'b0;
            for (int d = 0; d < ND; d++) begin
                n_vec++;
                if (act_v[d] !== exp_v[d]) begin
                    n_err++;
                    $display("FAIL random dut%0d cyc %0d: got %b want %b", d, cyc, act_v[d], exp_v[d]);
                end
            end
        end
    endtask

    initial begin
        for (int d = 0; d < ND; d++) begin
            init_i[d] = 1'b0;
            load_i[d] = 1'b0;
            word_i[d] = '0;
            m_kind[d] = K_NONE;
            m_start[d] = 0;
            m_word[d] = '0;
            m_pend[d] = 1'b0;
            m_pword[d] = '0;
            m_ipend[d] = 1'b0;
        end
        test_reset();
        test_auto_init();
        test_single_load();
        test_queued_load();
        test_init_during_load();
        test_back_to_back();
        test_reset_mid_shift();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
